// File: rtl/dwt_pkg.sv
// Shared constants, types and sample ROM for the single-level Daubechies-2 DWT stage.
package dwt_pkg;

  localparam int unsigned W_IN      = 9;
  localparam int unsigned C_IN      = 9;
  localparam int unsigned Y_OUT     = 25;
  localparam int unsigned N_SAMPLES = 48;
  localparam int unsigned N_OUT     = 24;
  localparam int unsigned GROUP     = 6;
  localparam int unsigned TAPS      = 4;
  localparam int unsigned ROM_AW    = 6;

  typedef enum logic {
    ST_RUN  = 1'b0,
    ST_DONE = 1'b1
  } state_e;

  // Quantized db2 decomposition filters, scaled by 256.
  localparam logic signed [C_IN-1:0] LO_D [TAPS] = '{
    C_IN'(-33), C_IN'(57), C_IN'(214), C_IN'(124)
  };
  localparam logic signed [C_IN-1:0] HI_D [TAPS] = '{
    C_IN'(-124), C_IN'(214), C_IN'(-57), C_IN'(-33)
  };

  // Input sequence x[n]; anything past the last sample reads as zero.
  function automatic logic signed [W_IN-1:0] sample_rom(input logic [ROM_AW-1:0] n);
    logic signed [W_IN-1:0] x;
    x = '0;
    if (n < ROM_AW'(N_SAMPLES)) begin
      x = W_IN'(n);
    end
    return x;
  endfunction

endpackage

// File: rtl/dwt_fir4.sv
// Combinational 4-tap signed multiply-accumulate at full precision.
module dwt_fir4 #(
  parameter int unsigned W = 9,
  parameter int unsigned C = 9
) (
  input  logic signed [W-1:0]   x_i    [4],
  input  logic signed [C-1:0]   coef_i [4],
  output logic signed [W+C+1:0] sum_o
);

  localparam int unsigned P_W = W + C;
  localparam int unsigned S_W = W + C + 2;

  logic signed [P_W-1:0] prod [4];
  logic signed [S_W-1:0] acc;

  always_comb begin
    acc = '0;
    for (int k = 0; k < 4; k++) begin
      prod[k] = P_W'(x_i[k]) * P_W'(coef_i[k]);
      acc     = acc + S_W'(prod[k]);
    end
  end

  assign sum_o = acc;

endmodule

// File: rtl/dwt_1.sv
// DWT analysis stage: walks the sample ROM, filters Lo/Hi in parallel, and
// publishes coefficients six at a time with a one-cycle valid pulse.
module dwt_1
  import dwt_pkg::*;
#(
  parameter int unsigned w_in  = W_IN,
  parameter int unsigned y_out = Y_OUT,
  parameter int unsigned c_in  = C_IN
) (
  input  logic                    clk,
  input  logic                    rstn,
  output logic signed [y_out-1:0] Hi_D_c_y_6k,
  output logic signed [y_out-1:0] Hi_D_c_y_6k_1,
  output logic signed [y_out-1:0] Hi_D_c_y_6k_2,
  output logic signed [y_out-1:0] Hi_D_c_y_6k_3,
  output logic signed [y_out-1:0] Hi_D_c_y_6k_4,
  output logic signed [y_out-1:0] Hi_D_c_y_6k_5,
  output logic                    Hi_D_valid,
  output logic signed [y_out-1:0] Lo_D_c_y_6k,
  output logic signed [y_out-1:0] Lo_D_c_y_6k_1,
  output logic signed [y_out-1:0] Lo_D_c_y_6k_2,
  output logic signed [y_out-1:0] Lo_D_c_y_6k_3,
  output logic signed [y_out-1:0] Lo_D_c_y_6k_4,
  output logic signed [y_out-1:0] Lo_D_c_y_6k_5,
  output logic                    Lo_D_valid
);

  localparam int unsigned SUM_W  = w_in + c_in + 2;
  localparam int unsigned M_W    = $clog2(N_OUT);
  localparam int unsigned SLOT_W = $clog2(GROUP);
  localparam int unsigned BANK_N = GROUP - 1;

  state_e                  state_q, state_d;
  logic [M_W-1:0]          m_q, m_d;
  logic [SLOT_W-1:0]       slot_q, slot_d;
  logic                    valid_q, valid_d;
  logic signed [y_out-1:0] lo_bank_q [BANK_N];
  logic signed [y_out-1:0] lo_bank_d [BANK_N];
  logic signed [y_out-1:0] hi_bank_q [BANK_N];
  logic signed [y_out-1:0] hi_bank_d [BANK_N];
  logic signed [y_out-1:0] lo_out_q  [GROUP];
  logic signed [y_out-1:0] lo_out_d  [GROUP];
  logic signed [y_out-1:0] hi_out_q  [GROUP];
  logic signed [y_out-1:0] hi_out_d  [GROUP];

  logic signed [w_in-1:0]  x_tap   [TAPS];
  logic signed [c_in-1:0]  lo_coef [TAPS];
  logic signed [c_in-1:0]  hi_coef [TAPS];
  logic signed [SUM_W-1:0] lo_sum, hi_sum;
  logic signed [y_out-1:0] lo_y, hi_y;

  // Tap k multiplies x[2m+3-k]; addresses past the ROM end read as zero.
  always_comb begin
    for (int k = 0; k < TAPS; k++) begin
      x_tap[k]   = w_in'(sample_rom(ROM_AW'({m_q, 1'b0}) + ROM_AW'(TAPS - 1 - k)));
      lo_coef[k] = c_in'(LO_D[k]);
      hi_coef[k] = c_in'(HI_D[k]);
    end
  end

  dwt_fir4 #(.W(w_in), .C(c_in)) u_fir_lo (
    .x_i    (x_tap),
    .coef_i (lo_coef),
    .sum_o  (lo_sum)
  );

  dwt_fir4 #(.W(w_in), .C(c_in)) u_fir_hi (
    .x_i    (x_tap),
    .coef_i (hi_coef),
    .sum_o  (hi_sum)
  );

  assign lo_y = y_out'(lo_sum);
  assign hi_y = y_out'(hi_sum);

  // Next-state: slot 5 bypasses the bank straight into the output registers.
  always_comb begin
    state_d   = state_q;
    m_d       = m_q;
    slot_d    = slot_q;
    valid_d   = 1'b0;
    lo_bank_d = lo_bank_q;
    hi_bank_d = hi_bank_q;
    lo_out_d  = lo_out_q;
    hi_out_d  = hi_out_q;

    unique case (state_q)
      ST_RUN: begin
        if (slot_q == SLOT_W'(GROUP - 1)) begin
          for (int i = 0; i < BANK_N; i++) begin
            lo_out_d[i] = lo_bank_q[i];
            hi_out_d[i] = hi_bank_q[i];
          end
          lo_out_d[GROUP-1] = lo_y;
          hi_out_d[GROUP-1] = hi_y;
          valid_d           = 1'b1;
          slot_d            = '0;
        end else begin
          for (int i = 0; i < BANK_N; i++) begin
            if (slot_q == SLOT_W'(i)) begin
              lo_bank_d[i] = lo_y;
              hi_bank_d[i] = hi_y;
            end
          end
          slot_d = slot_q + SLOT_W'(1);
        end

        if (m_q == M_W'(N_OUT - 1)) begin
          state_d = ST_DONE;
        end else begin
          m_d = m_q + M_W'(1);
        end
      end
      ST_DONE: begin
        state_d = ST_DONE;
      end
      default: begin
        state_d = ST_RUN;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rstn) begin
      state_q <= ST_RUN;
      m_q     <= '0;
      slot_q  <= '0;
      valid_q <= 1'b0;
      for (int i = 0; i < BANK_N; i++) begin
        lo_bank_q[i] <= '0;
        hi_bank_q[i] <= '0;
      end
      for (int i = 0; i < GROUP; i++) begin
        lo_out_q[i] <= '0;
        hi_out_q[i] <= '0;
      end
    end else begin
      state_q   <= state_d;
      m_q       <= m_d;
      slot_q    <= slot_d;
      valid_q   <= valid_d;
      lo_bank_q <= lo_bank_d;
      hi_bank_q <= hi_bank_d;
      lo_out_q  <= lo_out_d;
      hi_out_q  <= hi_out_d;
    end
  end

  assign Lo_D_c_y_6k   = lo_out_q[0];
  assign Lo_D_c_y_6k_1 = lo_out_q[1];
  assign Lo_D_c_y_6k_2 = lo_out_q[2];
  assign Lo_D_c_y_6k_3 = lo_out_q[3];
  assign Lo_D_c_y_6k_4 = lo_out_q[4];
  assign Lo_D_c_y_6k_5 = lo_out_q[5];
  assign Hi_D_c_y_6k   = hi_out_q[0];
  assign Hi_D_c_y_6k_1 = hi_out_q[1];
  assign Hi_D_c_y_6k_2 = hi_out_q[2];
  assign Hi_D_c_y_6k_3 = hi_out_q[3];
  assign Hi_D_c_y_6k_4 = hi_out_q[4];
  assign Hi_D_c_y_6k_5 = hi_out_q[5];
  assign Lo_D_valid    = valid_q;
  assign Hi_D_valid    = valid_q;

endmodule

// File: tb/tb_dwt_1.sv
// Self-checking bench for dwt_1: directed reset scenarios plus randomized
// reset timing, checked every cycle against an arithmetic reference model.
module tb_dwt_1;

  logic clk = 1'b0;
  logic rstn;
  logic signed [24:0] lo_o [6];
  logic signed [24:0] hi_o [6];
  logic lo_v, hi_v;

  int vectors     = 0;
  int miscompares = 0;
  int e           = 0;
  int pulses      = 0;
  int exp_lo [24];
  int exp_hi [24];

  always #5 clk = ~clk;

  dwt_1 dut (
    .clk           (clk),
    .rstn          (rstn),
    .Hi_D_c_y_6k   (hi_o[0]),
    .Hi_D_c_y_6k_1 (hi_o[1]),
    .Hi_D_c_y_6k_2 (hi_o[2]),
    .Hi_D_c_y_6k_3 (hi_o[3]),
    .Hi_D_c_y_6k_4 (hi_o[4]),
    .Hi_D_c_y_6k_5 (hi_o[5]),
    .Hi_D_valid    (hi_v),
    .Lo_D_c_y_6k   (lo_o[0]),
    .Lo_D_c_y_6k_1 (lo_o[1]),
    .Lo_D_c_y_6k_2 (lo_o[2]),
    .Lo_D_c_y_6k_3 (lo_o[3]),
    .Lo_D_c_y_6k_4 (lo_o[4]),
    .Lo_D_c_y_6k_5 (lo_o[5]),
    .Lo_D_valid    (lo_v)
  );

  function automatic int xs(input int n);
    return (n >= 0 && n < 48) ? n : 0;
  endfunction

  task automatic build_model();
    int lo_h [4];
    int hi_h [4];
    lo_h = '{-33, 57, 214, 124};
    hi_h = '{-124, 214, -57, -33};
    for (int m = 0; m < 24; m++) begin
      exp_lo[m] = 0;
      exp_hi[m] = 0;
      for (int k = 0; k < 4; k++) begin
        exp_lo[m] += lo_h[k] * xs(2 * m + 3 - k);
        exp_hi[m] += hi_h[k] * xs(2 * m + 3 - k);
      end
    end
  endtask

  task automatic chk(input string tag, input logic signed [31:0] obs,
                     input logic signed [31:0] expv);
    vectors++;
    assert (obs === expv) else begin
      miscompares++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
    end
  endtask

  // e = edges since reset released; group g is published at edge 6(g+1).
  task automatic check_outputs();
    int grp;
    logic expv;
    grp  = (e / 6 > 4) ? 4 : e / 6;
    expv = (e > 0 && e % 6 == 0 && e <= 24);
    chk($sformatf("lo_valid e=%0d", e), 32'(lo_v), 32'(expv));
    chk($sformatf("hi_valid e=%0d", e), 32'(hi_v), 32'(expv));
    for (int j = 0; j < 6; j++) begin
      chk($sformatf("lo%0d e=%0d", j, e), 32'(lo_o[j]),
          (grp == 0) ? 0 : exp_lo[(grp - 1) * 6 + j]);
      chk($sformatf("hi%0d e=%0d", j, e), 32'(hi_o[j]),
          (grp == 0) ? 0 : exp_hi[(grp - 1) * 6 + j]);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    if (rstn) e = 0;
    else      e++;
    #1;
    if (lo_v) pulses++;
    check_outputs();
  endtask

  task automatic run(input int n);
    rstn = 1'b0;
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic hold_reset(input int n);
    rstn = 1'b1;
    for (int i = 0; i < n; i++) tick();
  endtask

  initial begin
    build_model();
    rstn = 1'b1;

    hold_reset(3);

    // Full run into DONE, counting pulses.
    pulses = 0;
    run(100);
    chk("pulse_count", 32'(pulses), 32'd4);

    // Reset at edge 9 for one edge, then rerun.
    hold_reset(1);
    run(8);
    hold_reset(1);
    pulses = 0;
    run(30);
    chk("pulse_count_after_midreset", 32'(pulses), 32'd4);

    // Randomized reset timing.
    for (int r = 0; r < 8; r++) begin
      run(int'($urandom_range(1, 40)));
      hold_reset(int'($urandom_range(1, 3)));
    end

    run(40);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
